// File: rtl/crf_lut_bank_if.sv
// Pixel, result and configuration bundle for the CRF lookup bank.
// The host/source side uses master; the lookup bank uses slave.
interface crf_lut_bank_if #(
    parameter int unsigned PIXEL_W  = 5,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned CH_W     = 2
);
    logic                               clk_en;
    logic                               pix_valid;
    logic [CHANNELS*PIXEL_W-1:0]        pix_data;
    logic                               out_valid;
    logic [CHANNELS*DATA_W-1:0]         out_g;
    logic [CHANNELS*(PIXEL_W-1)-1:0]    out_w;
    logic                               cfg_wr;
    logic [CH_W-1:0]                    cfg_chan;
    logic [PIXEL_W-1:0]                 cfg_addr;
    logic [DATA_W-1:0]                  cfg_data;
    logic                               cfg_swap;
    logic                               frame_start;
    logic                               swap_pending;
    logic                               init_done;

    modport master (
        output clk_en, pix_valid, pix_data,
        output cfg_wr, cfg_chan, cfg_addr, cfg_data, cfg_swap, frame_start,
        input  out_valid, out_g, out_w, swap_pending, init_done
    );

    modport slave (
        input  clk_en, pix_valid, pix_data,
        input  cfg_wr, cfg_chan, cfg_addr, cfg_data, cfg_swap, frame_start,
        output out_valid, out_g, out_w, swap_pending, init_done
    );
endinterface

// File: rtl/crf_lut_bank.sv
// Double-buffered multi-channel CRF lookup: Z -> g(Z) from a runtime-loadable
// table plus a hat weight w(Z), two-cycle registered pipeline.
module crf_lut_bank #(
    parameter int unsigned PIXEL_W  = 5,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned CH_W     = 2
) (
    input logic           clk,
    input logic           rst,
    crf_lut_bank_if.slave bus
);
    localparam int unsigned DEPTH = 1 << PIXEL_W;
    localparam int unsigned WW    = PIXEL_W - 1;
    localparam int unsigned SHIFT = DATA_W - PIXEL_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [PIXEL_W-1:0] ZMAX   = '1;
    localparam logic [PIXEL_W-1:0] HALF   = ZMAX >> 1;
    localparam logic [CH_W:0]      CH_LIM = (CH_W+1)'(CHANNELS);

    logic [0:0]         state_q, state_d;
    logic [PIXEL_W-1:0] init_cnt_q, init_cnt_d;
    logic               bank_q, bank_d;
    logic               swap_pending_q, swap_pending_d;
    logic               init_done_q, init_done_d;

    logic                            s1_valid_q;
    logic [CHANNELS*PIXEL_W-1:0]     s1_pix_q;
    logic                            out_valid_q;
    logic [CHANNELS*DATA_W-1:0]      out_g_q;
    logic [CHANNELS*WW-1:0]          out_w_q;

    logic                            init_c, run_c, adv_c, cfg_ok_c;
    logic [PIXEL_W-1:0]              waddr_c;
    logic [DATA_W-1:0]               wdata_c;
    logic [CHANNELS*DATA_W-1:0]      rd_g_c;
    logic [CHANNELS*WW-1:0]          w_c;

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= '0;
            bank_q         <= 1'b0;
            swap_pending_q <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            bank_q         <= bank_d;
            swap_pending_q <= swap_pending_d;
            init_done_q    <= init_done_d;
        end
    end

    // Identity fill, then swap arbitration on frame boundaries
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        bank_d         = bank_q;
        swap_pending_d = swap_pending_q;
        init_done_d    = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + PIXEL_W'(1);
                if (init_cnt_q == ZMAX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.frame_start && (swap_pending_q || bus.cfg_swap)) begin
                    bank_d         = ~bank_q;
                    swap_pending_d = 1'b0;
                end else if (bus.cfg_swap) begin
                    swap_pending_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign init_c   = (state_q == ST_INIT);
    assign run_c    = (state_q == ST_RUN);
    assign adv_c    = run_c && bus.clk_en;
    assign cfg_ok_c = run_c && bus.cfg_wr && ({1'b0, bus.cfg_chan} < CH_LIM);
    assign waddr_c  = init_c ? init_cnt_q : bus.cfg_addr;
    assign wdata_c  = init_c ? (DATA_W'(init_cnt_q) << SHIFT) : bus.cfg_data;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0]  mem0 [DEPTH];
        logic [DATA_W-1:0]  mem1 [DEPTH];
        logic [DATA_W-1:0]  rd_q;
        logic [PIXEL_W-1:0] raddr;
        logic [PIXEL_W-1:0] z;
        logic [PIXEL_W-1:0] wf;
        logic               hit;

        assign raddr = bus.pix_data[c*PIXEL_W +: PIXEL_W];
        assign hit   = cfg_ok_c && (bus.cfg_chan == CH_W'(c));

        // INIT fills both banks; host writes only reach the shadow bank
        always_ff @(posedge clk) begin
            if (init_c || (hit && bank_q))  mem0[waddr_c] <= wdata_c;
            if (init_c || (hit && !bank_q)) mem1[waddr_c] <= wdata_c;
            if (adv_c) rd_q <= bank_q ? mem1[raddr] : mem0[raddr];
        end

        assign z  = s1_pix_q[c*PIXEL_W +: PIXEL_W];
        assign wf = (z <= HALF) ? z : (ZMAX - z);
        assign rd_g_c[c*DATA_W +: DATA_W] = rd_q;
        assign w_c[c*WW +: WW]            = WW'(wf);
    end

    // Lookup pipeline; frozen whenever clk_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            out_valid_q <= 1'b0;
            out_g_q     <= '0;
            out_w_q     <= '0;
        end else if (adv_c) begin
            s1_valid_q  <= bus.pix_valid;
            s1_pix_q    <= bus.pix_data;
            out_valid_q <= s1_valid_q;
            out_g_q     <= rd_g_c;
            out_w_q     <= w_c;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_g        = out_g_q;
    assign bus.out_w        = out_w_q;
    assign bus.swap_pending = swap_pending_q;
    assign bus.init_done    = init_done_q;
endmodule

// File: doc/crf_lut_bank.md
Name: crf_lut_bank

Overview:
- Multi-channel camera-response-function (CRF) lookup bank for the HDR merge datapath.
- Maps each packed channel pixel Z to a log-exposure value g(Z) and a hat weight w(Z).
- Successor to the fixed per-colour response ROMs: width, depth and channel count are parameters, and the curves are runtime-loadable.
- Double-buffered tables: the host writes a shadow bank, which becomes active only at a frame boundary.

Parameters:
- PIXEL_W, 5, bits per channel pixel; table depth is 2^PIXEL_W.
- DATA_W, 12, bits per g(Z) entry; must be >= PIXEL_W.
- CHANNELS, 3, number of independent channel tables and lanes.
- CH_W, 2, width of cfg_chan; must be >= clog2(CHANNELS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  pipeline advance enable; gates the lookup pipeline only.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_data  in  CHANNELS*PIXEL_W  packed pixels; channel c occupies bits [c*PIXEL_W +: PIXEL_W].
- out_valid  out  1  out_g and out_w are valid.
- out_g  out  CHANNELS*DATA_W  packed g(Z), same channel ordering as pix_data.
- out_w  out  CHANNELS*(PIXEL_W-1)  packed hat weights.
- cfg_wr  in  1  write strobe to the shadow bank.
- cfg_chan  in  CH_W  target channel.
- cfg_addr  in  PIXEL_W  table index.
- cfg_data  in  DATA_W  entry value.
- cfg_swap  in  1  request a bank swap at the next frame_start.
- frame_start  in  1  single-cycle frame boundary pulse.
- swap_pending  out  1  a swap request is armed.
- init_done  out  1  identity initialisation is complete.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_g=0, out_w=0, swap_pending=0, init_done=0, active bank select=0, FSM=INIT, init counter=0.
- Storage: two banks x CHANNELS tables x 2^PIXEL_W entries x DATA_W bits. Must be inferable as synchronous-read RAM.

FSM INIT:
- Each cycle writes entry i of every channel in both banks with the identity curve: i << (DATA_W-PIXEL_W), e.g. i=31 gives 3968 for 5/12.
- The counter increments every cycle; INIT ignores clk_en.
- After entry 2^PIXEL_W-1 is written, next state is RUN and init_done=1.
- INIT lasts exactly 2^PIXEL_W cycles after rst deasserts.

FSM RUN:
- Terminal state; only rst returns the FSM to INIT.

Reset mid-operation:
- Aborts any in-flight lookup and clears pending swaps.
- Restarts INIT; previously loaded curves are overwritten with identity.

Lookup pipeline (RUN and clk_en=1):
- Stage 1 (cycle N): issue reads at pix_data addresses from the active bank, sampled in cycle N. Register each pixel and pix_valid.
- Stage 2 (cycle N+1): register the read data into out_g. Register out_w from the stage-1 pixels. out_valid = stage-1 valid.
- Outputs are registered; data presented in cycle N is visible after the edge ending cycle N+1 (latency 2).
- clk_en=0: both stages and all outputs hold. Table writes and swap logic continue.
- pix_valid ignored while init_done=0; out_valid stays 0.

Weight:
- zmax = 2^PIXEL_W-1, half = zmax>>1.
- w = Z if Z<=half, else zmax-Z. Result is PIXEL_W-1 bits.
- Width 5 examples: w(0)=0, w(15)=15, w(16)=15, w(31)=0.

Config writes:
- cfg_wr in RUN writes bank ~active at [cfg_chan][cfg_addr].
- Ignored in INIT, and ignored if cfg_chan >= CHANNELS.
- A write never affects the active bank, so in-flight lookups are unaffected.

Swap:
- cfg_swap in RUN sets swap_pending.
- frame_start with swap_pending=1 (including a cfg_swap in the same cycle) toggles the active bank and clears swap_pending. The new bank is used by stage-1 reads from the next cycle onward.
- frame_start without a pending swap does nothing.
- cfg_swap while already pending has no further effect; there is a single pending slot.
- cfg_wr in the swap cycle targets the pre-toggle shadow bank, which is the bank becoming active.
- Contents are not copied between banks; after a swap the host must rewrite the new shadow bank if it wants both banks identical.

Test Plan:
- Reset then idle: init_done rises exactly 32 cycles after rst falls (default parameters). During INIT, pix_valid=1 with Z=0x1F on all lanes gives out_valid=0.
- Identity lookup: after INIT, pixel 0x01 on all lanes in cycle N. In cycle N+2, out_g lanes = 128, out_w lanes = 1, out_valid=1.
- Load and swap: write channel 1, address 0x05 = 0x22E, then cfg_swap. Lookup of Z=5 before frame_start gives lane1 = 640. frame_start shows swap_pending going 1->0. The next lookup gives lane1 = 0x22E, and lanes 0 and 2 still = 640.
- Edge cases: cfg_swap and frame_start asserted in the same cycle swap immediately. cfg_wr with cfg_chan=3 (CHANNELS=3) changes no table. A second frame_start with no request keeps the bank.
- clk_en stall: pixel presented, then clk_en=0 for 3 cycles. out_g/out_valid hold their prior values, and the result appears 2 enabled cycles after presentation.
- Reset mid-RUN after a loaded swap: all outputs return to 0, INIT reruns, and a lookup of Z=5 returns 640 on all lanes.
